// File: rtl/uart_pkg.sv
// Shared defaults and state encodings for the UART core and its bit timer.
package uart_pkg;

    localparam int unsigned WIDTH_DATA_DEF = 8;
    localparam int unsigned NB_STOP_DEF    = 2;
    localparam int unsigned CLK_SIZE_DEF   = 434;
    localparam int unsigned WIDTH_CLK_DEF  = 9;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with restart; emits registered ticks on the
// last cycle of a bit, the half-bit point and the second-to-last cycle.
module uart_bit_timer #(
    parameter int unsigned CLK_SIZE  = 434,
    parameter int unsigned WIDTH_CLK = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic full_o,
    output logic half_o,
    output logic near_o
);

    localparam logic [WIDTH_CLK-1:0] CNT_LAST = WIDTH_CLK'(CLK_SIZE - 1);
    localparam logic [WIDTH_CLK-1:0] CNT_HALF = WIDTH_CLK'(CLK_SIZE / 2 - 1);
    localparam logic [WIDTH_CLK-1:0] CNT_NEAR = WIDTH_CLK'(CLK_SIZE - 2);

    logic [WIDTH_CLK-1:0] cnt_q;
    logic [WIDTH_CLK-1:0] cnt_d;
    logic                 full_q;
    logic                 half_q;
    logic                 near_q;

    always_comb begin
        cnt_d = cnt_q + WIDTH_CLK'(1);
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Ticks are derived from the next count so they line up with cnt_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            half_q <= 1'b0;
            near_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CNT_LAST);
            half_q <= (cnt_d == CNT_HALF);
            near_q <= (cnt_d == CNT_NEAR);
        end
    end

    assign full_o = full_q;
    assign half_o = half_q;
    assign near_o = near_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: 8N2-style transmitter with back-to-back support and a
// mid-bit sampling receiver with glitch rejection, framing check and overrun.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int unsigned NB_STOP    = NB_STOP_DEF,
    parameter int unsigned CLK_SIZE   = CLK_SIZE_DEF,
    parameter int unsigned WIDTH_CLK  = WIDTH_CLK_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic                  i_we,
    output logic                  o_mty,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    input  logic                  i_re
);

    localparam int unsigned      W_IDX     = $clog2(WIDTH_DATA + 1);
    localparam logic [W_IDX-1:0] LAST_DATA = W_IDX'(WIDTH_DATA - 1);
    localparam logic [W_IDX-1:0] LAST_STOP = W_IDX'(NB_STOP - 1);

    tx_state_e             tx_state_q;
    logic [WIDTH_DATA-1:0] tx_shift_q;
    logic [W_IDX-1:0]      tx_idx_q;
    logic                  tx_q;
    logic                  mty_q;
    logic                  tx_restart_c;
    logic                  tx_full;
    logic                  tx_half;
    logic                  tx_near;

    rx_state_e             rx_state_q;
    logic                  rx_s1_q;
    logic                  rx_s2_q;
    logic                  rx_prev_q;
    logic [WIDTH_DATA-1:0] rx_shift_q;
    logic [W_IDX-1:0]      rx_idx_q;
    logic [WIDTH_DATA-1:0] data_q;
    logic                  rdy_q;
    logic                  rx_fall_c;
    logic                  rx_restart_c;
    logic                  rx_full;
    logic                  rx_half;
    logic                  rx_near;

    logic                  unused_ticks;

    assign unused_ticks = tx_half ^ rx_near;

    // ---------------- transmitter ----------------
    assign tx_restart_c = (tx_state_q == TX_IDLE) && i_we;

    uart_bit_timer #(
        .CLK_SIZE  (CLK_SIZE),
        .WIDTH_CLK (WIDTH_CLK)
    ) u_tx_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .restart_i (tx_restart_c),
        .full_o    (tx_full),
        .half_o    (tx_half),
        .near_o    (tx_near)
    );

    // The last stop bit hands over one cycle early so the idle cycle that
    // accepts the next write is itself the final cycle of that stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_q       <= 1'b1;
            mty_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (i_we) begin
                        tx_shift_q <= i_data;
                        tx_q       <= 1'b0;
                        mty_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_full) begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_full) begin
                        if (tx_idx_q == LAST_DATA) begin
                            tx_q       <= 1'b1;
                            tx_idx_q   <= '0;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + W_IDX'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_idx_q == LAST_STOP) begin
                        if (tx_near) begin
                            mty_q      <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end else if (tx_full) begin
                        tx_idx_q <= tx_idx_q + W_IDX'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= i_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Edge detection also provides re-arming after a framing error: a line
    // still low gives no new falling edge until it has returned high.
    assign rx_fall_c    = rx_prev_q & ~rx_s2_q;
    assign rx_restart_c = ((rx_state_q == RX_IDLE) && rx_fall_c) ||
                          ((rx_state_q == RX_START) && rx_half);

    uart_bit_timer #(
        .CLK_SIZE  (CLK_SIZE),
        .WIDTH_CLK (WIDTH_CLK)
    ) u_rx_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .restart_i (rx_restart_c),
        .full_o    (rx_full),
        .half_o    (rx_half),
        .near_o    (rx_near)
    );

    // A completing byte takes precedence over a simultaneous read acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            if (i_re) begin
                rdy_q <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall_c) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[WIDTH_DATA-1:1]};
                        if (rx_idx_q == LAST_DATA) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + W_IDX'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_full) begin
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            data_q <= rx_shift_q;
                            rdy_q  <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign o_tx   = tx_q;
    assign o_mty  = mty_q;
    assign o_data = data_q;
    assign o_rdy  = rdy_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback, back-to-back, glitch, framing error,
// overrun, read/complete collision and mid-frame reset.
module tb_uart_core;

    localparam int CLK = 434;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         re_at;
        logic       exp_rdy;
        logic [7:0] exp_data;
        logic       ack_after;
    } rx_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       we_drv;
    logic       mty;
    logic       rdy;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rx_drv;
    logic       re_drv;
    logic       loop_en;
    logic       re_follow;
    logic       rx_w;
    logic       re_w;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic       cap_rdy;
    logic [7:0] cap_data;
    rx_vec_t    vecs[6];

    assign rx_w = loop_en ? tx : rx_drv;
    assign re_w = re_follow ? rdy : re_drv;

    always #5 clk = ~clk;

    uart_core dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_rx   (rx_w),
        .o_tx   (tx),
        .i_data (din),
        .i_we   (we_drv),
        .o_mty  (mty),
        .o_data (dout),
        .o_rdy  (rdy),
        .i_re   (re_w)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Drives one frame on the receive line; optionally pulses i_re at cycle re_at.
    task automatic send_rx(input logic [7:0] d, input logic stop_bit, input int re_at);
        logic [11:0] bits;
        bits = {1'b1, 1'b1, stop_bit, d, 1'b0};
        for (int j = 0; j < 12 * CLK; j++) begin
            rx_drv = bits[j / CLK];
            re_drv = (j == re_at);
            if (j == re_at + 1) begin
                cap_rdy  = rdy;
                cap_data = dout;
            end
            tick(1);
        end
        re_drv = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_frame;
        int          rdy_at;
        int          n_rdy;
        int          wr2;
        int          n_cap;
        logic [7:0]  caps[4];
        logic [7:0]  got;

        vecs[0] = '{8'h3C, 1'b0, -1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h11, 1'b1, -1, 1'b1, 8'h11, 1'b0};
        vecs[2] = '{8'h22, 1'b1, -1, 1'b1, 8'h22, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, -1, 1'b0, 8'h22, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, -1, 1'b1, 8'h5A, 1'b0};
        vecs[5] = '{8'h77, 1'b1, 4125, 1'b1, 8'h77, 1'b0};

        rst = 1'b1; we_drv = 1'b0; din = 8'h00; rx_drv = 1'b1; re_drv = 1'b0;
        loop_en = 1'b1; re_follow = 1'b1;
        cap_rdy = 1'b0; cap_data = 8'h00;
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_mty", mty, 1);
        chk("rst_rdy", rdy, 0);
        chk("rst_data", dout, 8'h00);
        rst = 1'b0;
        tick(1);

        // Loopback 0xA5 with a write attempted mid-frame
        exp_frame = {2'b11, 8'hA5, 1'b0};
        we_drv = 1'b1; din = 8'hA5;
        tick(1);
        we_drv = 1'b0;
        chk("lb_mty_busy", mty, 0);
        rdy_at = -1; n_rdy = 0; got = 8'h00;
        for (int j = 0; j < 4800; j++) begin
            if ((j / CLK) < 11 && ((j % CLK) == 0 || (j % CLK) == CLK - 1))
                chk($sformatf("lb_tx_bit%0d_at%0d", j / CLK, j), tx, exp_frame[j / CLK]);
            if (rdy) begin
                n_rdy++;
                if (rdy_at < 0) begin
                    rdy_at = j;
                    got    = dout;
                end
            end
            if (j == 4772) chk("lb_mty_last_stop", mty, 0);
            if (j == 4773) chk("lb_mty_idle", mty, 1);
            we_drv = (j == 1000);
            din    = (j == 1000) ? 8'h00 : 8'hA5;
            tick(1);
        end
        we_drv = 1'b0;
        n_vec++;
        if (rdy_at < 4119 || rdy_at > 4127) begin
            n_fail++;
            $display("FAIL lb_rdy_latency: got %0d cycles, expected 4119..4127", rdy_at);
        end
        chk("lb_rdy_pulse_len", n_rdy, 1);
        chk("lb_rx_data", got, 8'hA5);

        // Back-to-back 0x00 then 0xFF
        we_drv = 1'b1; din = 8'h00;
        tick(1);
        we_drv = 1'b0;
        wr2 = -1; n_cap = 0;
        for (int j = 0; j < 9400; j++) begin
            if (wr2 >= 0 && j == wr2 + 1) chk("b2b_no_gap", tx, 0);
            we_drv = 1'b0;
            if (mty && wr2 < 0) begin
                chk("b2b_stop_high", tx, 1);
                we_drv = 1'b1;
                din    = 8'hFF;
                wr2    = j;
            end
            if (rdy) begin
                if (n_cap < 4) caps[n_cap] = dout;
                n_cap++;
            end
            tick(1);
        end
        we_drv = 1'b0;
        chk("b2b_write_cycle", wr2, 11 * CLK - 1);
        chk("b2b_rx_count", n_cap, 2);
        chk("b2b_rx_first", caps[0], 8'h00);
        chk("b2b_rx_second", caps[1], 8'hFF);

        // Direct-drive mode for the receiver tests
        loop_en = 1'b0; re_follow = 1'b0; rx_drv = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        rx_drv = 1'b0;
        tick(100);
        rx_drv = 1'b1;
        tick(1000);
        chk("glitch_rdy", rdy, 0);
        chk("glitch_data", dout, 8'h00);

        for (int v = 0; v < 6; v++) begin
            send_rx(vecs[v].data, vecs[v].stop_bit, vecs[v].re_at);
            if (vecs[v].re_at >= 0) begin
                chk($sformatf("vec%0d_collide_rdy", v), cap_rdy, 1);
                chk($sformatf("vec%0d_collide_data", v), cap_data, vecs[v].exp_data);
            end
            chk($sformatf("vec%0d_rdy", v), rdy, vecs[v].exp_rdy);
            chk($sformatf("vec%0d_data", v), dout, vecs[v].exp_data);
            if (vecs[v].ack_after) begin
                re_drv = 1'b1;
                tick(1);
                re_drv = 1'b0;
                chk($sformatf("vec%0d_ack_clr", v), rdy, 0);
            end
        end

        // Reset in the middle of a loopback frame
        loop_en = 1'b1;
        we_drv = 1'b1; din = 8'h96;
        tick(1);
        we_drv = 1'b0;
        tick(1500);
        rst = 1'b1;
        tick(1);
        chk("midrst_tx", tx, 1);
        chk("midrst_mty", mty, 1);
        chk("midrst_rdy", rdy, 0);
        chk("midrst_data", dout, 8'h00);
        rst = 1'b0;
        n_rdy = 0;
        for (int j = 0; j < 6000; j++) begin
            if (rdy) n_rdy++;
            tick(1);
        end
        chk("midrst_no_rdy", n_rdy, 0);
        chk("midrst_tx_idle", tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter WIDTH_DATA, default 8: data bits per frame.
REQ-002 Parameter NB_STOP, default 2: stop bits per transmitted frame (legal values 1 or 2).
REQ-003 Parameter CLK_SIZE, default 434: clock cycles per bit (50 MHz / 115200).
REQ-004 Parameter WIDTH_CLK, default 9: bit-timer counter width, at least clog2(CLK_SIZE).
REQ-005 Port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-007 Port i_rx, input, 1: asynchronous serial receive line, idle high.
REQ-008 Port o_tx, output, 1: serial transmit line, idle high.
REQ-009 Port i_data, input, WIDTH_DATA: byte to transmit.
REQ-010 Port i_we, input, 1: transmit write strobe.
REQ-011 Port o_mty, output, 1: transmitter empty; a write is accepted.
REQ-012 Port o_data, output, WIDTH_DATA: last received byte.
REQ-013 Port o_rdy, output, 1: received byte valid.
REQ-014 Port i_re, input, 1: read acknowledge; clears o_rdy.

Function
REQ-015 Frame format: start bit 0, WIDTH_DATA data bits LSB first, then NB_STOP stop bits of 1; no parity; each bit lasts exactly CLK_SIZE cycles.
REQ-016 TX states: IDLE, START, DATA, STOP. o_mty is 1 only in IDLE.
REQ-017 In IDLE with i_we=1 at a clock edge, TX latches i_data, and on the next cycle o_tx=0 (START) and o_mty=0.
REQ-018 i_we while o_mty=0 is ignored; the frame in progress and its latched data are unaffected.
REQ-019 After the last stop-bit period, TX returns to IDLE with o_mty=1; a write in that same cycle starts the next frame back-to-back, with no extra idle bit.
REQ-020 RX passes i_rx through a 2-flop synchronizer before any use.
REQ-021 RX states: IDLE, START, DATA, STOP. A synchronized falling edge in IDLE enters START.
REQ-022 RX samples at mid-bit (CLK_SIZE/2 cycles into START, then every CLK_SIZE cycles).
REQ-023 If the start-bit sample is 1, the event is a glitch: RX returns to IDLE and produces no output.
REQ-024 RX checks the first stop bit only and returns to IDLE at its mid-bit sample; it ignores further stop bits.
REQ-025 Stop sample 0 is a framing error: RX discards the byte, leaves o_data and o_rdy unchanged, and waits for i_rx high before re-arming.
REQ-026 Valid stop sample: o_data is loaded and o_rdy=1 on the next cycle.
REQ-027 o_rdy stays 1 until i_re=1; it then clears on the following edge. i_re while o_rdy=0 has no effect.
REQ-028 Overrun: a new valid byte arriving while o_rdy=1 overwrites o_data and o_rdy stays 1.
REQ-029 New byte completing in the same cycle as i_re=1: the new byte is loaded and o_rdy stays 1.
REQ-030 TX and RX are fully independent; full-duplex and external loopback (o_tx tied to i_rx) are legal.
REQ-031 Bit counters wrap at CLK_SIZE-1 and never exceed WIDTH_CLK bits.

Reset
REQ-032 While i_rst=1 at a clock edge: o_tx=1, o_mty=1, o_rdy=0, o_data=0, both FSMs in IDLE, all counters and synchronizer flops cleared to idle-high/zero as appropriate.
REQ-033 Reset mid-frame aborts both directions immediately; the partial frame is discarded with no o_rdy pulse.

Structure
REQ-034 Package uart_pkg holds the parameter defaults and the TX/RX state encodings.
REQ-035 One sub-module, uart_bit_timer (WIDTH_CLK counter with restart input and full-bit/half-bit ticks), is instantiated once for TX and once for RX; all other logic is in uart_core.

Verification
REQ-036 Loopback test: o_tx tied to i_rx, i_re tied to o_rdy, write 0xA5 -> o_tx shows 0,1,0,1,0,0,1,0,1,1,1, each bit 434 cycles; o_data=0xA5 with o_rdy pulsed for one cycle about 4123±4 cycles after the write.
REQ-037 Back-to-back test: write 0x00 then 0xFF on successive o_mty -> o_tx has no gap between frames; both bytes are received in order.
REQ-038 Glitch test: 100-cycle low pulse on i_rx -> no o_rdy, and RX returns to IDLE.
REQ-039 Framing-error test: drive 0x3C with stop bit 0 -> o_rdy stays 0 and o_data is unchanged.
REQ-040 Overrun test: i_re held 0, receive 0x11 then 0x22 -> o_rdy=1 and o_data=0x22.
REQ-041 Reset-mid-frame test: assert i_rst during DATA -> the next cycle shows o_tx=1, o_mty=1, o_rdy=0, o_data=0.
